taillight_monitor: RTL and testbench

Receive-side monitor for the six tail-light lamp lines (LA, LB, LC, RA, RB, RC) driven by the turn-signal controller FSM. It samples the lamp pattern every clock and decodes it back into a mode code. It checks every pattern-to-pattern transition against the legal turn, hazard and brake sequences, and counts completed sweeps, flashes and protocol errors. It sits in the same clock domain as the controller and feeds status and diagnostics to the top level.

---
 rtl/taillight_monitor.sv | 171 +++++++++++++++++
 tb/tb_taillight_monitor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/taillight_monitor.sv
// Tail-light lamp-line monitor: decodes lamp patterns, checks turn/hazard/brake sequencing, counts events.
// Optional TL_MON_STICKY_ERR_EN makes seq_err hold until clr or reset.
module taillight_monitor #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             clr,
  input  logic             LA,
  input  logic             LB,
  input  logic             LC,
  input  logic             RA,
  input  logic             RB,
  input  logic             RC,
  output logic [2:0]       mode,
  output logic [CNT_W-1:0] left_sweeps,
  output logic [CNT_W-1:0] right_sweeps,
  output logic [CNT_W-1:0] flash_count,
  output logic [CNT_W-1:0] err_count,
  output logic             seq_err,
  output logic             stuck_err
);

  localparam int unsigned HOLD_W = $clog2(HOLD_MAX + 1);

  typedef enum logic [2:0] {
    M_IDLE = 3'd0,
    M_L1   = 3'd1,
    M_L2   = 3'd2,
    M_L3   = 3'd3,
    M_R1   = 3'd4,
    M_R2   = 3'd5,
    M_R3   = 3'd6,
    M_ALL  = 3'd7
  } mode_e;

  logic [5:0]        pat_q;
  logic              clr_q;
  mode_e             prev_q, prev_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  left_q, left_d, right_q, right_d, flash_q, flash_d, err_q, err_d;
  logic              seq_err_q, seq_err_d, stuck_q, stuck_d;
  mode_e             dec_c;
  logic              legal_c;
  logic              err_ev_c;
  logic              sticky_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic trans_ok(input mode_e from, input mode_e to);
    logic ok;
    ok = (from == to);
    case (from)
      M_IDLE:            ok = ok | (to == M_L1) | (to == M_R1) | (to == M_ALL);
      M_L1:              ok = ok | (to == M_L2) | (to == M_IDLE);
      M_L2:              ok = ok | (to == M_L3) | (to == M_IDLE);
      M_R1:              ok = ok | (to == M_R2) | (to == M_IDLE);
      M_R2:              ok = ok | (to == M_R3) | (to == M_IDLE);
      M_L3, M_R3, M_ALL: ok = ok | (to == M_IDLE);
      default:           ok = 1'b0;
    endcase
    return ok;
  endfunction

`ifdef TL_MON_STICKY_ERR_EN
  assign sticky_c = seq_err_q;
`else
  assign sticky_c = 1'b0;
`endif

  // Pattern decode, bit order {LA,LB,LC,RA,RB,RC}
  always_comb begin
    dec_c   = M_IDLE;
    legal_c = 1'b1;
    case (pat_q)
      6'b000000: dec_c = M_IDLE;
      6'b100000: dec_c = M_L1;
      6'b110000: dec_c = M_L2;
      6'b111000: dec_c = M_L3;
      6'b000100: dec_c = M_R1;
      6'b000110: dec_c = M_R2;
      6'b000111: dec_c = M_R3;
      6'b111111: dec_c = M_ALL;
      default:   legal_c = 1'b0;
    endcase
  end

  // Transition tracking, event counting and hold timing
  always_comb begin
    prev_d    = prev_q;
    hold_d    = hold_q;
    left_d    = left_q;
    right_d   = right_q;
    flash_d   = flash_q;
    err_d     = err_q;
    err_ev_c  = 1'b0;

    if (!legal_c) begin
      err_ev_c = 1'b1;
      prev_d   = M_IDLE;
      hold_d   = '0;
    end else if (dec_c == prev_q) begin
      hold_d = (hold_q >= HOLD_W'(HOLD_MAX)) ? hold_q : hold_q + HOLD_W'(1);
    end else begin
      hold_d   = '0;
      prev_d   = dec_c;
      err_ev_c = !trans_ok(prev_q, dec_c);
      if (dec_c == M_IDLE) begin
        case (prev_q)
          M_L3:    left_d  = sat_inc(left_q);
          M_R3:    right_d = sat_inc(right_q);
          M_ALL:   flash_d = sat_inc(flash_q);
          default: ;
        endcase
      end
    end

    if (err_ev_c) err_d = sat_inc(err_q);
    seq_err_d = err_ev_c | sticky_c;
    stuck_d   = (hold_d >= HOLD_W'(HOLD_MAX)) && (prev_d != M_IDLE);

    // Clear wins over anything counted this cycle; the tracker still follows the lamps
    if (clr_q) begin
      hold_d    = '0;
      left_d    = '0;
      right_d   = '0;
      flash_d   = '0;
      err_d     = '0;
      seq_err_d = 1'b0;
      stuck_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pat_q     <= '0;
      clr_q     <= 1'b0;
      prev_q    <= M_IDLE;
      hold_q    <= '0;
      left_q    <= '0;
      right_q   <= '0;
      flash_q   <= '0;
      err_q     <= '0;
      seq_err_q <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      pat_q     <= {LA, LB, LC, RA, RB, RC};
      clr_q     <= clr;
      prev_q    <= prev_d;
      hold_q    <= hold_d;
      left_q    <= left_d;
      right_q   <= right_d;
      flash_q   <= flash_d;
      err_q     <= err_d;
      seq_err_q <= seq_err_d;
      stuck_q   <= stuck_d;
    end
  end

  assign mode         = prev_q;
  assign left_sweeps  = left_q;
  assign right_sweeps = right_q;
  assign flash_count  = flash_q;
  assign err_count    = err_q;
  assign seq_err      = seq_err_q;
  assign stuck_err    = stuck_q;

endmodule

// File: tb/tb_taillight_monitor.sv
// Scoreboard bench for taillight_monitor: stimulus queues expected outputs, a monitor compares them.
module tb_taillight_monitor;

  localparam int unsigned CNT_W = 8;
  localparam int X = -1;

  localparam logic [5:0] P_IDLE = 6'b000000;
  localparam logic [5:0] P_L1   = 6'b100000;
  localparam logic [5:0] P_L2   = 6'b110000;
  localparam logic [5:0] P_L3   = 6'b111000;
  localparam logic [5:0] P_R1   = 6'b000100;
  localparam logic [5:0] P_R2   = 6'b000110;
  localparam logic [5:0] P_R3   = 6'b000111;
  localparam logic [5:0] P_ALL  = 6'b111111;
  localparam logic [5:0] P_BAD  = 6'b101010;

`ifdef TL_MON_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             Reset_n;
  logic             clr;
  logic             LA, LB, LC, RA, RB, RC;
  logic [2:0]       mode;
  logic [CNT_W-1:0] left_sweeps, right_sweeps, flash_count, err_count;
  logic             seq_err, stuck_err;

  taillight_monitor #(.CNT_W(CNT_W), .HOLD_MAX(15)) dut (
    .clk(clk), .Reset_n(Reset_n), .clr(clr),
    .LA(LA), .LB(LB), .LC(LC), .RA(RA), .RB(RB), .RC(RC),
    .mode(mode), .left_sweeps(left_sweeps), .right_sweeps(right_sweeps),
    .flash_count(flash_count), .err_count(err_count),
    .seq_err(seq_err), .stuck_err(stuck_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    m;
    int    ls;
    int    rs;
    int    fc;
    int    ec;
    int    se;
    int    st;
    string tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   sticky_m = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    if (exp < 0) return;
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one sample and queue what the outputs must show once it has been processed
  task automatic step(input logic [5:0] pat, input logic c, input int m, input int ls,
                      input int rs, input int fc, input int ec, input bit err_now,
                      input int st, input string tag);
    exp_t e;
    bit   se;
    @(negedge clk);
    {LA, LB, LC, RA, RB, RC} = pat;
    clr = c;
    se = c ? 1'b0 : (err_now | (STICKY & sticky_m));
    sticky_m = se;
    e.m = m; e.ls = ls; e.rs = rs; e.fc = fc; e.ec = ec;
    e.se = int'(se); e.st = st; e.tag = tag;
    q.push_back(e);
  endtask

  // Monitor: a sample captured at edge N is visible after edge N+1
  exp_t pend;
  bit   pend_v = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pend_v) begin
        chk({pend.tag, "/mode"},      int'(mode),         pend.m);
        chk({pend.tag, "/left"},      int'(left_sweeps),  pend.ls);
        chk({pend.tag, "/right"},     int'(right_sweeps), pend.rs);
        chk({pend.tag, "/flash"},     int'(flash_count),  pend.fc);
        chk({pend.tag, "/errcnt"},    int'(err_count),    pend.ec);
        chk({pend.tag, "/seq_err"},   int'(seq_err),      pend.se);
        chk({pend.tag, "/stuck_err"}, int'(stuck_err),    pend.st);
      end
      pend_v = 1'b0;
      if (q.size() > 0) begin
        pend   = q.pop_front();
        pend_v = 1'b1;
      end
    end
  end

  initial begin
    Reset_n = 1'b0;
    clr     = 1'b0;
    {LA, LB, LC, RA, RB, RC} = P_L2;
    repeat (2) @(negedge clk);
    chk("reset/mode",      int'(mode),         0);
    chk("reset/left",      int'(left_sweeps),  0);
    chk("reset/right",     int'(right_sweeps), 0);
    chk("reset/flash",     int'(flash_count),  0);
    chk("reset/errcnt",    int'(err_count),    0);
    chk("reset/seq_err",   int'(seq_err),      0);
    chk("reset/stuck_err", int'(stuck_err),    0);
    @(posedge clk);
    #2 Reset_n = 1'b1;

    // Tracking restarts from IDLE: L2 as first sample is a sequence error
    step(P_L2,   1'b0, 2, 0, 0, 0, 1, 1'b1, 0, "rst_l2");
    step(P_IDLE, 1'b0, 0, 0, 0, 0, 1, 1'b0, 0, "rst_idle");
    step(P_IDLE, 1'b1, 0, 0, 0, 0, 0, 1'b0, 0, "rst_clr");

    // Left sweep
    step(P_IDLE, 1'b0, 0, 0, 0, 0, 0, 1'b0, 0, "left_idle");
    step(P_L1,   1'b0, 1, 0, 0, 0, 0, 1'b0, 0, "left_l1");
    step(P_L2,   1'b0, 2, 0, 0, 0, 0, 1'b0, 0, "left_l2");
    step(P_L3,   1'b0, 3, 0, 0, 0, 0, 1'b0, 0, "left_l3");
    step(P_IDLE, 1'b0, 0, 1, 0, 0, 0, 1'b0, 0, "left_done");

    // Three hazard flashes
    for (int i = 0; i < 3; i++) begin
      step(P_ALL,  1'b0, 7, 1, 0, i,     0, 1'b0, 0, "flash_on");
      step(P_IDLE, 1'b0, 0, 1, 0, i + 1, 0, 1'b0, 0, "flash_off");
    end

    // Skipped step into R2 resyncs, then R3 is legal
    step(P_R2,   1'b0, 5, 1, 0, 3, 1, 1'b1, 0, "skip_r2");
    step(P_R3,   1'b0, 6, 1, 0, 3, 1, 1'b0, 0, "skip_r3");
    step(P_IDLE, 1'b0, 0, 1, 1, 3, 1, 1'b0, 0, "skip_idle");

    // Illegal patterns, single and back-to-back
    step(P_BAD,  1'b0, 0, 1, 1, 3, 2, 1'b1, 0, "bad1");
    step(P_IDLE, 1'b0, 0, 1, 1, 3, 2, 1'b0, 0, "bad1_idle");
    step(P_BAD,  1'b0, 0, 1, 1, 3, 3, 1'b1, 0, "bad2a");
    step(P_BAD,  1'b0, 0, 1, 1, 3, 4, 1'b1, 0, "bad2b");
    step(P_IDLE, 1'b0, 0, 1, 1, 3, 4, 1'b0, 0, "bad2_idle");

    // Stuck detection on a held L1
    for (int k = 1; k <= 20; k++)
      step(P_L1, 1'b0, 1, 1, 1, 3, 4, 1'b0, (k >= 16) ? 1 : 0, "hold_l1");
    step(P_L2,   1'b0, 2, 1, 1, 3, 4, 1'b0, 0, "hold_l2");
    step(P_L3,   1'b0, 3, 1, 1, 3, 4, 1'b0, 0, "hold_l3");
    step(P_IDLE, 1'b0, 0, 2, 1, 3, 4, 1'b0, 0, "hold_done");
    for (int k = 0; k < 100; k++)
      step(P_IDLE, 1'b0, 0, 2, 1, 3, 4, 1'b0, 0, "idle_long");

    // Right sweeps up to and past saturation
    for (int i = 0; i < 255; i++) begin
      step(P_R1,   1'b0, 4, X, X, X, X, 1'b0, 0, "sat_r1");
      step(P_R2,   1'b0, 5, X, X, X, X, 1'b0, 0, "sat_r2");
      step(P_R3,   1'b0, 6, X, X, X, X, 1'b0, 0, "sat_r3");
      step(P_IDLE, 1'b0, 0, 2, (i + 2 > 255) ? 255 : i + 2, 3, 4, 1'b0, 0, "sat_idle");
    end

    // clr coincident with a counted R3 -> IDLE transition
    step(P_R1,   1'b0, 4, X, X, X, X, 1'b0, 0, "clr_r1");
    step(P_R2,   1'b0, 5, X, X, X, X, 1'b0, 0, "clr_r2");
    step(P_R3,   1'b0, 6, 2, 255, 3, 4, 1'b0, 0, "clr_r3");
    step(P_IDLE, 1'b1, 0, 0, 0, 0, 0, 1'b0, 0, "clr_idle");
    step(P_IDLE, 1'b0, 0, 0, 0, 0, 0, 1'b0, 0, "clr_after");

    // A lone error followed by quiet cycles, then clr
    step(P_BAD,  1'b0, 0, 0, 0, 0, 1, 1'b1, 0, "lone_bad");
    for (int k = 0; k < 3; k++)
      step(P_IDLE, 1'b0, 0, 0, 0, 0, 1, 1'b0, 0, "lone_idle");
    step(P_IDLE, 1'b1, 0, 0, 0, 0, 0, 1'b0, 0, "lone_clr");
    step(P_IDLE, 1'b0, 0, 0, 0, 0, 0, 1'b0, 0, "lone_after");

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0 || pend_v) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
